div_seq: RTL and testbench

Sequential 32-bit integer divider that serves the multicycle MIPS core's DIV/DIVU requests. The control unit issues a one-cycle `start` with operands from registers A and B. This block iterates one quotient bit per clock and answers with a one-cycle `done`, or with `div_zero` when the divisor is zero. Its `lo` (quotient) and `hi` (remainder) outputs feed the HI/LO source muxes, and `div_zero` feeds the control unit's exception input.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_seq_if.sv | 35 +++
 rtl/div_step.sv | 39 +++
 rtl/div_seq.sv | 145 ++++++++++++++
 tb/tb_div_seq.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the sequential divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    FIX  = 3'd2,
    DONE = 3'd3,
    ZERO = 3'd4
  } div_state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_if
//  Description : Request/response bundle between the control unit (master)
//                and the sequential divider (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface div_seq_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, div_zero, lo, hi
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, div_zero, lo, hi
  );

endinterface : div_seq_if
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division iteration. Shifts the
//                next dividend bit into the partial remainder, trial-subtracts
//                the divisor and shifts the resulting quotient bit in.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  // One extra bit: the shifted remainder can reach 2*divisor-1.
  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;

  assign w_shifted = {i_rem, i_quo[WIDTH-1]};
  assign w_trial   = w_shifted - {1'b0, i_divisor};

  // Keep the subtraction only when it did not borrow.
  always_comb begin
    o_rem = w_shifted[WIDTH-1:0];
    o_quo = {i_quo[WIDTH-2:0], 1'b0};
    if (!w_trial[WIDTH]) begin
      o_rem    = w_trial[WIDTH-1:0];
      o_quo[0] = 1'b1;
    end
  end

endmodule : div_step
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq
//  Description : Sequential WIDTH-bit integer divider (DIV/DIVU). One quotient
//                bit per clock, WIDTH+2 cycle latency, divide-by-zero pulse.
//                Build option: DIV_SIGNED_EN enables signed operation; when
//                undefined every request is treated as unsigned.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic     clock,
  input  logic     reset,
  div_seq_if.slave bus
);

  localparam int               CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  div_state_t       r_state;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divMag;
  logic             r_busy;
  logic             r_done;
  logic             r_divZero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] w_magA;
  logic [WIDTH-1:0] w_magB;
  logic [WIDTH-1:0] w_remNext;
  logic [WIDTH-1:0] w_quoNext;
  logic [WIDTH-1:0] w_hiFix;
  logic [WIDTH-1:0] w_loFix;

`ifdef DIV_SIGNED_EN
  logic r_negQ;
  logic r_negR;
  logic w_negA;
  logic w_negB;

  // Magnitudes fit WIDTH bits unsigned, including the most negative value.
  assign w_negA  = bus.signed_op & bus.dividend[WIDTH-1];
  assign w_negB  = bus.signed_op & bus.divisor[WIDTH-1];
  assign w_magA  = w_negA ? -bus.dividend : bus.dividend;
  assign w_magB  = w_negB ? -bus.divisor  : bus.divisor;
  // Quotient negated on differing signs; remainder follows the dividend.
  assign w_loFix = r_negQ ? -r_quo : r_quo;
  assign w_hiFix = r_negR ? -r_rem : r_rem;
`else
  assign w_magA  = bus.dividend;
  assign w_magB  = bus.divisor;
  assign w_loFix = r_quo;
  assign w_hiFix = r_rem;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divMag),
    .o_rem     (w_remNext),
    .o_quo     (w_quoNext)
  );

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divMag  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_divZero <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
`ifdef DIV_SIGNED_EN
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_divZero <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            if (bus.divisor == '0) begin
              // No iteration; hi/lo keep their previous values.
              r_state   <= ZERO;
              r_done    <= 1'b1;
              r_divZero <= 1'b1;
            end else begin
              r_state  <= RUN;
              r_count  <= '0;
              r_rem    <= '0;
              r_quo    <= w_magA;
              r_divMag <= w_magB;
`ifdef DIV_SIGNED_EN
              r_negQ   <= w_negA ^ w_negB;
              r_negR   <= w_negA;
`endif
            end
          end
        end
        RUN: begin
          r_rem   <= w_remNext;
          r_quo   <= w_quoNext;
          r_count <= r_count + 1'b1;
          if (r_count == C_LAST) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_hi    <= w_hiFix;
          r_lo    <= w_loFix;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE, ZERO: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_divZero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule : div_seq
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_seq
//  Description : Self-checking bench for div_seq: directed cases plus random
//                requests compared every cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_div_seq;
  import div_pkg::*;

  localparam int W = DIV_WIDTH;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  div_seq_if #(.WIDTH(W)) bus ();

  div_seq #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int nChecks = 0;
  int nErrors = 0;
  bit checkOn = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference division from plain integer arithmetic; returns {hi, lo}.
  function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint qa, qb, q, r;
    if (s && SIGNED_EN) begin
      qa = $signed(a);
      qb = $signed(b);
    end else begin
      qa = longint'({32'b0, a});
      qb = longint'({32'b0, b});
    end
    q = qa / qb;
    r = qa % qb;
    return {r[31:0], q[31:0]};
  endfunction

  // Behavioural model: a countdown of busy cycles and the visible hi/lo.
  int          mLeft = 0;
  logic        mZero = 1'b0;
  logic [31:0] mHi = '0, mLo = '0, pHi = '0, pLo = '0;

  always @(posedge clock) begin
    if (reset) begin
      mLeft <= 0;
      mZero <= 1'b0;
      mHi   <= '0;
      mLo   <= '0;
    end else if (mLeft == 0) begin
      if (bus.start) begin
        if (bus.divisor == '0) begin
          mLeft <= 1;
          mZero <= 1'b1;
        end else begin
          mLeft <= DIV_LATENCY;
          mZero <= 1'b0;
          {pHi, pLo} <= refDiv(bus.dividend, bus.divisor, bus.signed_op);
        end
      end
    end else begin
      mLeft <= mLeft - 1;
      if (mLeft == 2 && !mZero) begin
        mHi <= pHi;
        mLo <= pLo;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (checkOn) begin
      chk("busy",     64'(bus.busy),     64'(mLeft > 0));
      chk("done",     64'(bus.done),     64'(mLeft == 1));
      chk("div_zero", 64'(bus.div_zero), 64'(mLeft == 1 && mZero));
      chk("hi",       64'(bus.hi),       64'(mHi));
      chk("lo",       64'(bus.lo),       64'(mLo));
    end
  end

  // Issue one request in the next cycle and wait for done (bounded).
  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input int injectAt, output int lat,
                       output logic [31:0] hiV, output logic [31:0] loV, output logic dz);
    @(negedge clock);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b; bus.signed_op = s;
    @(negedge clock);
    bus.start = 1'b0; bus.dividend = $urandom; bus.divisor = $urandom; bus.signed_op = 1'($urandom);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 60) begin
      @(negedge clock);
      lat++;
      if (lat == injectAt) begin
        bus.start = 1'b1; bus.dividend = $urandom; bus.divisor = $urandom_range(1, 100);
      end else begin
        bus.start = 1'b0;
      end
    end
    hiV = bus.hi;
    loV = bus.lo;
    dz  = bus.div_zero;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] hiV, loV, a, b;
    logic        dz, s;

    reset = 1'b1;
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clock);
    checkOn = 1'b1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b0;

    // DIVU 100 / 7
    runOp(32'd100, 32'd7, 1'b0, 0, lat, hiV, loV, dz);
    chk("divu100_7_lat", 64'(lat), 64'd34);
    chk("divu100_7_lo", 64'(loV), 64'd14);
    chk("divu100_7_hi", 64'(hiV), 64'd2);
    chk("divu100_7_dz", 64'(dz), 64'd0);

    // Divide by zero with hi/lo preloaded to 2/14
    runOp(32'd55, 32'd0, 1'b0, 0, lat, hiV, loV, dz);
    chk("dz_lat", 64'(lat), 64'd1);
    chk("dz_flag", 64'(dz), 64'd1);
    chk("dz_hold", {hiV, loV}, {32'd2, 32'd14});
    @(negedge clock);
    chk("dz_busy_c2", 64'(bus.busy), 64'd0);

    runOp(32'hFFFF_FFF9, 32'd2, 1'b1, 0, lat, hiV, loV, dz);
`ifdef DIV_SIGNED_EN
    chk("div_m7_2", {hiV, loV}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
`else
    chk("div_m7_2", {hiV, loV}, {32'd1, 32'h7FFF_FFFC});
`endif
    runOp(32'd7, 32'hFFFF_FFFE, 1'b1, 0, lat, hiV, loV, dz);
`ifdef DIV_SIGNED_EN
    chk("div_7_m2", {hiV, loV}, {32'd1, 32'hFFFF_FFFD});
`else
    chk("div_7_m2", {hiV, loV}, {32'd7, 32'd0});
`endif
    runOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, lat, hiV, loV, dz);
`ifdef DIV_SIGNED_EN
    chk("div_min_m1", {hiV, loV}, {32'd0, 32'h8000_0000});
`else
    chk("div_min_m1", {hiV, loV}, {32'h8000_0000, 32'd0});
`endif
    runOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, lat, hiV, loV, dz);
    chk("divu_min_m1", {hiV, loV}, {32'h8000_0000, 32'd0});

    // Second start in cycle 5 must be ignored
    runOp(32'd1000, 32'd3, 1'b0, 5, lat, hiV, loV, dz);
    chk("ignore_lat", 64'(lat), 64'd34);
    chk("ignore_res", {hiV, loV}, {32'd1, 32'd333});

    // Reset in cycle 10 of a run, restart in cycle 11
    @(negedge clock);
    bus.start = 1'b1; bus.dividend = 32'd200; bus.divisor = 32'd9; bus.signed_op = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      bus.start = 1'b0;
      if (c == 10) reset = 1'b1;
    end
    @(negedge clock);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b0;
    bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
    lat = 11;
    @(negedge clock);
    lat++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && lat < 80) begin
      @(negedge clock);
      lat++;
    end
    chk("rst_restart_cycle", 64'(lat), 64'd45);
    chk("rst_restart_res", {bus.hi, bus.lo}, {32'd0, 32'd10});

    // Randomized requests
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      s = 1'($urandom);
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = $urandom_range(1, 15);
        2:       b = $urandom;
        3:       b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
        default: b = a >> $urandom_range(0, 31);
      endcase
      runOp(a, b, s, 0, lat, hiV, loV, dz);
      chk("rand_lat", 64'(lat), (b == '0) ? 64'd1 : 64'd34);
      if (b != '0) chk("rand_res", {hiV, loV}, refDiv(a, b, s));
    end

    @(negedge clock);
    checkOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule : tb_div_seq
`default_nettype wire
